shift_reg_univ: RTL and testbench

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_univ.sv | 118 +++++++++++
 tb/tb_shift_reg_univ.sv | 133 +++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift / parallel load / rotate over DEPTH
// stages of WIDTH bits, with a saturating count of valid stages.

module shift_reg_univ_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] i_shift_d,
  input  logic [WIDTH-1:0] i_rot_d,
  input  logic [WIDTH-1:0] i_load_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      case (mode)
        2'b01:   r_q <= i_shift_d;
        2'b10:   r_q <= i_load_d;
        2'b11:   r_q <= i_rot_d;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

module shift_reg_univ #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           sin,
  input  logic [WIDTH*DEPTH-1:0]     pin,
  output logic [WIDTH-1:0]           sout,
  output logic [WIDTH*DEPTH-1:0]     pout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] w_stage;
  logic [DEPTH-1:0][WIDTH-1:0] w_pin;
  logic [CW-1:0]               r_count;
  logic                        r_full;
  logic                        r_empty;

  assign w_pin = pin;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_shift_d;
    logic [WIDTH-1:0] w_rot_d;

    // Stage 0 takes sin on shift and the last stage on rotate.
    if (g == 0) begin : g_head
      assign w_shift_d = sin;
      assign w_rot_d   = w_stage[DEPTH-1];
    end else begin : g_body
      assign w_shift_d = w_stage[g-1];
      assign w_rot_d   = w_stage[g-1];
    end

    shift_reg_univ_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .i_shift_d (w_shift_d),
      .i_rot_d   (w_rot_d),
      .i_load_d  (w_pin[g]),
      .o_q       (w_stage[g])
    );
  end

  // full/empty are registered alongside count so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (en) begin
      case (mode)
        2'b01: begin
          if (r_count != FULL_CNT) r_count <= r_count + 1'b1;
          r_full  <= (r_count >= FULL_CNT - 1'b1);
          r_empty <= 1'b0;
        end
        2'b10: begin
          r_count <= FULL_CNT;
          r_full  <= 1'b1;
          r_empty <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign pout  = w_stage;
  assign sout  = w_stage[DEPTH-1];
  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: table of 4x1 vectors plus an 8-bit x3 sequence.

module tb_shift_reg_univ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4, WIDTH=1 instance
  logic       rst, en, sin, sout, full, empty;
  logic [1:0] mode;
  logic [3:0] pin, pout;
  logic [2:0] count;

  shift_reg_univ #(.WIDTH(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pin(pin),
    .sout(sout), .pout(pout), .count(count), .full(full), .empty(empty)
  );

  // DEPTH=3, WIDTH=8 instance
  logic        rst8, en8, full8, empty8;
  logic [1:0]  mode8;
  logic [7:0]  sin8, sout8;
  logic [23:0] pin8, pout8;
  logic [1:0]  count8;

  shift_reg_univ #(.WIDTH(8), .DEPTH(3)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .sin(sin8), .pin(pin8),
    .sout(sout8), .pout(pout8), .count(count8), .full(full8), .empty(empty8)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin;
    logic [3:0] pin;
    logic [3:0] exp_pout;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic s,
                     input logic [3:0] p, input logic [3:0] ep, input logic [2:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sin = s; v.pin = p;
    v.exp_pout = ep; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    // rst en mode sin pin  -> pout count ; pout bit i = stage i
    add(1, 0, 2'b00, 0, 4'h0, 4'b0000, 0);   // reset
    add(0, 1, 2'b01, 1, 4'h0, 4'b0001, 1);   // shift 1,0,1,1
    add(0, 1, 2'b01, 0, 4'h0, 4'b0010, 2);
    add(0, 1, 2'b01, 1, 4'h0, 4'b0101, 3);
    add(0, 1, 2'b01, 1, 4'h0, 4'b1011, 4);   // full, sout = first bit
    add(0, 1, 2'b00, 1, 4'hF, 4'b1011, 4);   // hold
    add(0, 1, 2'b01, 0, 4'h0, 4'b0110, 4);   // shifts while full: saturate
    add(0, 1, 2'b01, 0, 4'h0, 4'b1100, 4);
    add(0, 1, 2'b01, 0, 4'h0, 4'b1000, 4);
    add(0, 1, 2'b10, 0, 4'hA, 4'b1010, 4);   // load 1010
    add(0, 1, 2'b11, 1, 4'h0, 4'b0101, 4);   // 4 rotates, sin ignored
    add(0, 1, 2'b11, 1, 4'h0, 4'b1010, 4);
    add(0, 1, 2'b11, 0, 4'h0, 4'b0101, 4);
    add(0, 1, 2'b11, 1, 4'h0, 4'b1010, 4);
    add(0, 0, 2'b01, 1, 4'hF, 4'b1010, 4);   // en=0 in all active modes
    add(0, 0, 2'b10, 1, 4'hF, 4'b1010, 4);
    add(0, 0, 2'b11, 1, 4'hF, 4'b1010, 4);
    add(0, 0, 2'b01, 0, 4'h5, 4'b1010, 4);
    add(0, 0, 2'b10, 1, 4'h0, 4'b1010, 4);
    add(1, 1, 2'b10, 1, 4'hF, 4'b0000, 0);   // rst beats load
    add(0, 1, 2'b11, 1, 4'hF, 4'b0000, 0);   // rotate while empty
    add(0, 1, 2'b01, 1, 4'h0, 4'b0001, 1);
    add(0, 1, 2'b11, 0, 4'h0, 4'b0010, 1);   // rotate keeps count
    add(0, 1, 2'b11, 0, 4'h0, 4'b0100, 1);
    add(0, 1, 2'b11, 0, 4'h0, 4'b1000, 1);
    add(0, 1, 2'b11, 0, 4'h0, 4'b0001, 1);   // wrapped
    add(1, 1'bx, 2'bxx, 1'bx, 4'hx, 4'b0000, 0); // X inputs under reset
    add(0, 1, 2'b10, 0, 4'h6, 4'b0110, 4);

    rst8 = 1'b1; en8 = 1'b0; mode8 = 2'b00; sin8 = '0; pin8 = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      sin = vecs[i].sin; pin = vecs[i].pin;
      @(posedge clk); #1;
      chk("pout",  i, 32'(pout),  32'(vecs[i].exp_pout));
      chk("count", i, 32'(count), 32'(vecs[i].exp_cnt));
      chk("sout",  i, 32'(sout),  32'(vecs[i].exp_pout[3]));
      chk("full",  i, 32'(full),  32'(vecs[i].exp_cnt == 3'd4));
      chk("empty", i, 32'(empty), 32'(vecs[i].exp_cnt == 3'd0));
    end

    // 8-bit lanes, 3 stages
    rst8 = 1'b1; @(posedge clk); #1;
    chk("w8_rst_pout",  0, 32'(pout8),  32'h0);
    chk("w8_rst_empty", 0, 32'(empty8), 32'h1);
    rst8 = 1'b0; en8 = 1'b1; mode8 = 2'b01;
    sin8 = 8'hA5; @(posedge clk); #1;
    chk("w8_sout", 1, 32'(sout8), 32'h00);
    sin8 = 8'h3C; @(posedge clk); #1;
    chk("w8_sout", 2, 32'(sout8), 32'h00);
    chk("w8_full", 2, 32'(full8), 32'h0);
    sin8 = 8'hFF; @(posedge clk); #1;
    chk("w8_sout",  3, 32'(sout8),  32'hA5);
    chk("w8_pout",  3, 32'(pout8),  32'hA53CFF);
    chk("w8_count", 3, 32'(count8), 32'h3);
    chk("w8_full",  3, 32'(full8),  32'h1);
    mode8 = 2'b11; sin8 = 8'h00; @(posedge clk); #1;
    chk("w8_rot_pout", 4, 32'(pout8),  32'h3CFFA5);
    chk("w8_rot_cnt",  4, 32'(count8), 32'h3);
    mode8 = 2'b10; pin8 = 24'h123456; en8 = 1'b0; @(posedge clk); #1;
    chk("w8_en0_pout", 5, 32'(pout8), 32'h3CFFA5);
    en8 = 1'b1; @(posedge clk); #1;
    chk("w8_load_pout", 6, 32'(pout8), 32'h123456);
    chk("w8_load_sout", 6, 32'(sout8), 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
